rr_select_arbiter: RTL

- Round-robin arbiter plus output register that drives the `select` input of the parameterised selection mux.
- Arbitrates among `SIZE` requesters, each presenting a `WIDTH`-bit payload, and picks one winner per accepted cycle.
- Holds the winner's index and payload in a registered valid/ready output slot feeding the downstream consumer.
- Sits in the issue/dispatch path of the FPGA core, between per-slot request logic and the stage that consumes the selected entry.

---
 rtl/rr_select_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rr_select_arbiter.sv
// rr_select_arbiter
//   Round-robin arbiter with a registered valid/ready output slot. The held
//   index drives the select input of the downstream selection mux, and the
//   held payload travels with it.
//
// Optional feature macro: RR_ARB_PRIO_EN
//   When defined, a prio mask restricts the search to req & prio whenever
//   that set is non-empty.
//
// Parameters
//   BITS   width of the index field (2**BITS >= SIZE)
//   SIZE   number of requesters
//   WIDTH  payload width per requester
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   req         per-requester request
//   in_data     flattened payloads, requester i at [WIDTH*(i+1)-1 -: WIDTH]
//   prio        priority mask (RR_ARB_PRIO_EN only)
//   grant       one-hot combinational grant for the accepted requester
//   out_valid   output slot holds a selection
//   out_ready   consumer accepts the slot this cycle
//   out_select  registered index of the held winner
//   out_data    registered payload of the held winner
module rr_select_arbiter #(
    parameter int BITS  = 2,
    parameter int SIZE  = 4,
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SIZE-1:0]       req,
    input  logic [SIZE*WIDTH-1:0] in_data,
`ifdef RR_ARB_PRIO_EN
    input  logic [SIZE-1:0]       prio,
`endif
    output logic [SIZE-1:0]       grant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS-1:0]       out_select,
    output logic [WIDTH-1:0]      out_data
);

    logic [BITS-1:0]  ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [BITS-1:0]  out_select_q, out_select_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic [SIZE-1:0]  search;
    logic             found;
    logic [BITS-1:0]  win;
    logic             ld;
    int               idx;

    // Slot can take a new entry when empty or being drained this cycle.
    assign ld = !out_valid_q || out_ready;

    // Priority restriction only applies when some prioritised requester is
    // actually asking; otherwise plain round-robin over all of req.
`ifdef RR_ARB_PRIO_EN
    assign search = ((req & prio) != '0) ? (req & prio) : req;
`else
    assign search = req;
`endif

    // Circular search from ptr. ptr never exceeds SIZE-1, so one
    // conditional subtraction implements the wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < SIZE; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= SIZE) idx = idx - SIZE;
            if (!found && search[idx]) begin
                found = 1'b1;
                win   = BITS'(idx);
            end
        end
    end

    // Grant is forced low during reset because an empty slot would
    // otherwise make ld true and grant a live request.
    always_comb begin
        grant = '0;
        if (rst && ld && found) grant[win] = 1'b1;
    end

    always_comb begin
        ptr_d        = ptr_q;
        out_valid_d  = out_valid_q;
        out_select_d = out_select_q;
        out_data_d   = out_data_q;
        if (ld) begin
            if (found) begin
                out_valid_d  = 1'b1;
                out_select_d = win;
                out_data_d   = in_data[WIDTH*int'(win) +: WIDTH];
                ptr_d        = (win == BITS'(SIZE-1)) ? '0 : win + 1'b1;
            end else begin
                out_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_select_q <= '0;
            out_data_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_select_q <= out_select_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_select = out_select_q;
    assign out_data   = out_data_q;

endmodule
